// File: rtl/axis_checksum_appender.sv
// AXI-Stream pass-through that appends a running-sum checksum beat
// after each packet, with forced termination at MAX_PKT_LEN beats.
module axis_checksum_appender #(
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_PKT_LEN = 256,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                    axis_aclk,
  input  logic                    axis_reset,
  input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
  input  logic                    s01_axis_tvalid,
  input  logic                    s01_axis_tlast,
  output logic                    s01_axis_tready,
  output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
  output logic                    m01_axis_tvalid,
  output logic                    m01_axis_tlast,
  input  logic                    m01_axis_tready,
  output logic [CNT_WIDTH-1:0]    pkt_count,
  output logic                    overflow_err
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int BW = $clog2(MAX_PKT_LEN + 1);

  typedef enum logic {
    PASS,
    CSUM
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] masked;
  logic [BW-1:0]         beat_cnt;
  logic                  out_free;
  logic                  accept;
  logic                  hit;

  assign out_free = !m01_axis_tvalid || m01_axis_tready;
  assign s01_axis_tready = !axis_reset && (state == PASS) && out_free;
  assign accept = s01_axis_tvalid && s01_axis_tready;
  assign hit = (beat_cnt + 1'b1) == BW'(MAX_PKT_LEN);

  always_comb begin
    masked = '0;
    for (int i = 0; i < SW; i++) begin
      if (s01_axis_tstrb[i]) begin
        masked[i*8 +: 8] = s01_axis_tdata[i*8 +: 8];
      end
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      PASS: if (accept && (s01_axis_tlast || hit)) state_next = CSUM;
      CSUM: if (out_free) state_next = PASS;
      default: state_next = PASS;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) state <= PASS;
    else            state <= state_next;
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      m01_axis_tdata  <= '0;
      m01_axis_tstrb  <= '0;
      m01_axis_tvalid <= 1'b0;
      m01_axis_tlast  <= 1'b0;
      sum             <= '0;
      beat_cnt        <= '0;
      pkt_count       <= '0;
      overflow_err    <= 1'b0;
    end else begin
      unique case (state)
        PASS: begin
          if (accept) begin
            m01_axis_tdata  <= s01_axis_tdata;
            m01_axis_tstrb  <= s01_axis_tstrb;
            m01_axis_tlast  <= 1'b0;
            m01_axis_tvalid <= 1'b1;
            sum             <= sum + masked;
            beat_cnt        <= beat_cnt + 1'b1;
            // a packet ending on the limit beat with tlast is not an overflow
            if (hit && !s01_axis_tlast) overflow_err <= 1'b1;
          end else if (m01_axis_tready) begin
            m01_axis_tvalid <= 1'b0;
          end
        end
        CSUM: begin
          if (out_free) begin
            m01_axis_tdata  <= sum;
            m01_axis_tstrb  <= '1;
            m01_axis_tlast  <= 1'b1;
            m01_axis_tvalid <= 1'b1;
            sum             <= '0;
            beat_cnt        <= '0;
            pkt_count       <= pkt_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_checksum_appender.sv
// Directed bench for axis_checksum_appender with an output-order
// scoreboard; MAX_PKT_LEN is 4 so forced termination is reachable.
module tb_axis_checksum_appender;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_data = '0;
  logic [3:0]  s_strb = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [31:0] m_data;
  logic [3:0]  m_strb;
  logic        m_valid;
  logic        m_last;
  logic        m_ready = 1'b1;
  logic [15:0] pkt_count;
  logic        overflow_err;

  beat_t q[$];
  int    total = 0;
  int    passed = 0;

  axis_checksum_appender #(
    .DATA_WIDTH(32),
    .MAX_PKT_LEN(4),
    .CNT_WIDTH(16)
  ) dut (
    .axis_aclk(clk),
    .axis_reset(rst),
    .s01_axis_tdata(s_data),
    .s01_axis_tstrb(s_strb),
    .s01_axis_tvalid(s_valid),
    .s01_axis_tlast(s_last),
    .s01_axis_tready(s_ready),
    .m01_axis_tdata(m_data),
    .m01_axis_tstrb(m_strb),
    .m01_axis_tvalid(m_valid),
    .m01_axis_tlast(m_last),
    .m01_axis_tready(m_ready),
    .pkt_count(pkt_count),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic expect_beat(input logic [31:0] d, input logic [3:0] s,
                             input logic l);
    beat_t b;
    b.d = d;
    b.s = s;
    b.l = l;
    q.push_back(b);
  endtask

  // Monitor: a beat presented with ready at the negedge transfers next edge.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", m_data, 32'hDEAD_BEEF);
      end else begin
        beat_t b;
        b = q.pop_front();
        chk("out_data", m_data, b.d);
        chk("out_strb", {28'd0, m_strb}, {28'd0, b.s});
        chk("out_last", {31'd0, m_last}, {31'd0, b.l});
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic [3:0] s,
                      input logic l);
    logic rdy;
    logic ok;
    ok = 1'b0;
    expect_beat(d, s, 1'b0);
    s_data  = d;
    s_strb  = s;
    s_last  = l;
    s_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("send_accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #2;
      if (q.size() == 0) break;
    end
    chk("drain_empty", q.size(), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_sready", {31'd0, s_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    chk("rst_mvalid", {31'd0, m_valid}, 32'd0);
    chk("rst_pkt", {16'd0, pkt_count}, 32'd0);
    chk("rst_ovf", {31'd0, overflow_err}, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("init_sready", {31'd0, s_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("init_mvalid", {31'd0, m_valid}, 32'd0);
    chk("init_pkt", {16'd0, pkt_count}, 32'd0);
    chk("init_ovf", {31'd0, overflow_err}, 32'd0);

    // basic three-beat packet
    send(32'h55, 4'hF, 1'b0);
    send(32'h22, 4'hF, 1'b0);
    send(32'h24, 4'hF, 1'b1);
    expect_beat(32'h9B, 4'hF, 1'b1);
    drain();
    chk("pkt_after_basic", {16'd0, pkt_count}, 32'd1);

    // backpressure for five cycles mid-packet
    send(32'h11, 4'hF, 1'b0);
    m_ready = 1'b0;
    s_data  = 32'h22;
    s_strb  = 4'hF;
    s_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_sready", {31'd0, s_ready}, 32'd0);
      chk("bp_hold_data", m_data, 32'h11);
      chk("bp_hold_valid", {31'd0, m_valid}, 32'd1);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    send(32'h22, 4'hF, 1'b0);
    send(32'h33, 4'hF, 1'b1);
    expect_beat(32'h66, 4'hF, 1'b1);
    // next packet arrives while checksum is pending and must stall
    send(32'hFFFF_FFFF, 4'hF, 1'b0);
    send(32'h2, 4'hF, 1'b1);
    expect_beat(32'h1, 4'hF, 1'b1);
    drain();
    chk("pkt_after_wrap", {16'd0, pkt_count}, 32'd3);

    // strobe masking on a single-beat packet
    send(32'h1234_5678, 4'h3, 1'b1);
    expect_beat(32'h0000_5678, 4'hF, 1'b1);
    drain();
    chk("pkt_after_strb", {16'd0, pkt_count}, 32'd4);
    chk("ovf_before", {31'd0, overflow_err}, 32'd0);

    // forced termination at four beats
    do_reset();
    for (int i = 0; i < 4; i++) send(32'h1, 4'hF, 1'b0);
    expect_beat(32'h4, 4'hF, 1'b1);
    send(32'h1, 4'hF, 1'b0);
    send(32'h1, 4'hF, 1'b1);
    expect_beat(32'h2, 4'hF, 1'b1);
    drain();
    chk("ovf_set", {31'd0, overflow_err}, 32'd1);
    chk("pkt_after_ovf", {16'd0, pkt_count}, 32'd2);

    // reset mid-packet discards the partial packet
    send(32'hA, 4'hF, 1'b0);
    send(32'hB, 4'hF, 1'b0);
    do_reset();
    send(32'h10, 4'hF, 1'b1);
    expect_beat(32'h10, 4'hF, 1'b1);
    drain();
    chk("pkt_after_rst", {16'd0, pkt_count}, 32'd1);
    chk("ovf_after_rst", {31'd0, overflow_err}, 32'd0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axis_checksum_appender.md
AXIS_CHECKSUM_APPENDER -- requirements
Module: axis_checksum_appender

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the tdata width in bits; tstrb width is DATA_WIDTH/8.
REQ-002 SHALL have parameter MAX_PKT_LEN, default 256, giving the maximum data beats per packet before forced termination.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, giving the packet counter width.
REQ-004 SHALL use one clock and a synchronous, active-high reset; there are no other clocks.
REQ-005 SHALL provide ports as follows:
- axis_aclk, input, 1 -- the single clock.
- axis_reset, input, 1 -- synchronous, active-high reset.
- s01_axis_tdata, input, DATA_WIDTH -- upstream data, fed from the memory_wrapper m01 port.
- s01_axis_tstrb, input, DATA_WIDTH/8 -- byte qualifiers.
- s01_axis_tvalid, input, 1 -- upstream beat valid.
- s01_axis_tlast, input, 1 -- last beat of the upstream packet.
- s01_axis_tready, output, 1 -- block accepts a beat.
- m01_axis_tdata, output, DATA_WIDTH -- downstream data.
- m01_axis_tstrb, output, DATA_WIDTH/8 -- downstream byte qualifiers.
- m01_axis_tvalid, output, 1 -- downstream beat valid.
- m01_axis_tlast, output, 1 -- asserted only on the checksum beat.
- m01_axis_tready, input, 1 -- downstream accepts a beat.
- pkt_count, output, CNT_WIDTH -- number of completed packets; wraps modulo 2^CNT_WIDTH.
- overflow_err, output, 1 -- sticky flag for a forced-terminated packet.

Function
REQ-006 SHALL define a beat as transferred on a rising edge where tvalid=1 and tready=1 on that side.
REQ-007 SHALL hold the output in a single-entry register (m01 tdata/tstrb/tlast/tvalid); no combinational path SHALL exist from s01 inputs to m01 outputs.
REQ-008 SHALL implement two states, PASS and CSUM.
REQ-009 In PASS, SHALL drive s01_axis_tready = !m01_axis_tvalid || m01_axis_tready; in CSUM, SHALL drive s01_axis_tready = 0.
REQ-010 In PASS, on an accepted beat, SHALL load the output register with tdata and tstrb, force tlast to 0 and set tvalid to 1, so output latency is 1 cycle.
REQ-011 SHALL update the running sum on each accepted beat as sum += masked tdata, modulo 2^DATA_WIDTH; bytes whose tstrb bit is 0 contribute 0.
REQ-012 SHALL increment a beat counter on each accepted beat.
REQ-013 SHALL go PASS->CSUM after accepting a beat with s01_axis_tlast=1, or after accepting the beat that makes the beat count equal to MAX_PKT_LEN (forced termination).
REQ-014 On forced termination, SHALL set overflow_err=1 and keep it set until reset.
REQ-015 Any upstream beats that follow a forced termination SHALL be treated as a new packet.
REQ-016 In CSUM, when the output register is empty or is being consumed this cycle, SHALL load tdata = final sum (including the last data beat), tstrb = all ones, tlast = 1, tvalid = 1.
REQ-017 In the same cycle as REQ-016, SHALL clear the sum and beat count, increment pkt_count, and return to PASS.
REQ-018 The checksum beat SHALL therefore appear no earlier than the cycle after the last data beat leaves the output register.
REQ-019 m01 outputs SHALL remain stable while m01_axis_tvalid=1 and m01_axis_tready=0.
REQ-020 A single-beat packet SHALL produce one data beat followed by one checksum beat equal to that beat's masked data.
REQ-021 A tvalid=1 with tlast=1 arriving while in CSUM SHALL be stalled, not dropped.

Reset
REQ-022 While axis_reset=1 at a clock edge, SHALL clear: m01_axis_tvalid, m01_axis_tlast, m01_axis_tdata, m01_axis_tstrb, sum, beat count, pkt_count and overflow_err; SHALL set state=PASS.
REQ-023 During reset, s01_axis_tready SHALL be 0.
REQ-024 Reset asserted mid-packet SHALL discard the partial packet and any pending checksum; the first beat accepted after reset starts a new packet.

Verification
REQ-025 Bench SHALL drive 0x55, 0x22, 0x24 (tlast on 0x24), tstrb=0xF, m01_axis_tready=1 -> outputs 0x55, 0x22, 0x24 with tlast=0, then 0x9B with tlast=1 and tstrb=0xF; pkt_count=1.
REQ-026 Bench SHALL apply backpressure: m01_axis_tready=0 for 5 cycles mid-packet -> output held stable, s01_axis_tready=0, no beat lost or duplicated, checksum unchanged.
REQ-027 Bench SHALL check wrap: beats 0xFFFFFFFF then 0x00000002 (tlast) -> checksum 0x00000001.
REQ-028 Bench SHALL check strobe masking: single beat 0x12345678 with tstrb=0x3 and tlast -> data beat 0x12345678 with tstrb=0x3, then checksum 0x00005678.
REQ-029 Bench SHALL check overflow: MAX_PKT_LEN=4, 6 beats of 0x1 with no tlast, then tlast -> checksum 0x4 after beat 4, overflow_err=1; beats 5-6 form a packet with checksum 0x2; pkt_count=2.
REQ-030 Bench SHALL check reset mid-packet: axis_reset pulsed after 2 beats, then packet 0x10 (tlast) -> outputs 0x10 then checksum 0x10; pkt_count=1.
